vec_mem_sequencer: RTL and testbench

Memory-side consumer of the execute-stage vector operands. For a vector store it serialises a 16-lane × 32-bit operand onto a single-word memory port. For a vector load it gathers 16 words back into a vector for writeback. It sits between the execute pipeline register and data memory, and stalls the pipeline while a vector access is in flight.

---
 rtl/vec_mem_sequencer.sv | 152 +++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_mem_sequencer
//
// Memory-side consumer of the execute-stage vector operands. A vector store
// is serialised lane by lane onto a single-word memory port. A vector load
// issues one read per lane and gathers the returned words into a vector for
// writeback. The upstream pipeline is stalled while an access is in flight.
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   start         vector memory op request from the execute stage
//   is_store      1 = store, 0 = load (sampled with start)
//   base_addr     byte address of lane 0 (sampled with start)
//   store_vec     store operand, LANES x DW (sampled with start)
//   wa3_in        destination vector register for loads (sampled with start)
//   stall         freeze the upstream pipeline registers
//   done          one-cycle completion pulse
//   load_vec      gathered load result
//   wa3_out       captured destination register
//   vreg_we       writeback enable (done of a load)
//   mem_req       memory request
//   mem_we        write strobe, qualified by mem_req
//   mem_addr      byte address of the current lane
//   mem_wdata     lane data for stores
//   mem_gnt       request accepted this cycle
//   mem_rvalid    read data valid
//   mem_rdata     read data
// ---------------------------------------------------------------------------
module vec_mem_sequencer #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [AW-1:0]            base_addr,
    input  logic [LANES-1:0][DW-1:0] store_vec,
    input  logic [3:0]               wa3_in,
    output logic                     stall,
    output logic                     done,
    output logic [LANES-1:0][DW-1:0] load_vec,
    output logic [3:0]               wa3_out,
    output logic                     vreg_we,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DW-1:0]            mem_rdata
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_t;

    state_t                    r_state;
    logic [LW-1:0]             r_lane;
    logic                      r_is_store;
    logic [AW-1:0]             r_base;
    logic [LANES-1:0][DW-1:0]  r_store_vec;
    logic [LANES-1:0][DW-1:0]  r_load_vec;
    logic [3:0]                r_wa3;

    logic                      w_last;
    logic [AW-1:0]             w_addr;

    assign w_last = (r_lane == LW'(LANES - 1));

    // Lanes are word-sized, so the lane index is scaled by 4; the sum wraps
    // modulo 2^AW with the carry out discarded.
    assign w_addr = r_base + (AW'(r_lane) << 2);

    // Sequencer FSM. Every captured operand lives in a register, so the
    // memory-side outputs below are pure decodes of registered state and stay
    // stable while a request waits for its grant. Reset also clears the
    // gathered load vector, so an aborted load leaves nothing behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_lane      <= '0;
            r_is_store  <= 1'b0;
            r_base      <= '0;
            r_store_vec <= '0;
            r_load_vec  <= '0;
            r_wa3       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_store  <= is_store;
                        r_base      <= base_addr;
                        r_store_vec <= store_vec;
                        r_wa3       <= wa3_in;
                        r_lane      <= '0;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (!r_is_store) begin
                            r_state <= WAIT_R;
                        end else if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_lane <= r_lane + LW'(1);
                        end
                    end
                end
                WAIT_R: begin
                    // Only one read is ever outstanding, so rvalid here
                    // always belongs to the current lane.
                    if (mem_rvalid) begin
                        r_load_vec[r_lane] <= mem_rdata;
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_lane  <= r_lane + LW'(1);
                            r_state <= REQ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances on the completion cycle;
    // a start held high through DONE is therefore first seen again in IDLE.
    assign stall     = ((r_state == IDLE) && start) || (r_state == REQ) || (r_state == WAIT_R);
    assign done      = (r_state == DONE);
    assign vreg_we   = (r_state == DONE) && !r_is_store;
    assign mem_req   = (r_state == REQ);
    assign mem_we    = (r_state == REQ) && r_is_store;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_store_vec[r_lane];
    assign load_vec  = r_load_vec;
    assign wa3_out   = r_wa3;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_sequencer
//
// Directed bench for vec_mem_sequencer. Expected memory transactions are
// queued when an op is launched and popped as the DUT presents granted
// requests; load results, writeback register and completion cycle are
// predicted by the bench itself.
// ---------------------------------------------------------------------------
module tb_vec_mem_sequencer;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic                     start;
    logic                     is_store;
    logic [AW-1:0]            base_addr;
    logic [LANES-1:0][DW-1:0] store_vec;
    logic [3:0]               wa3_in;
    logic                     stall;
    logic                     done;
    logic [LANES-1:0][DW-1:0] load_vec;
    logic [3:0]               wa3_out;
    logic                     vreg_we;
    logic                     mem_req;
    logic                     mem_we;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_wdata;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [DW-1:0]            mem_rdata;

    vec_mem_sequencer #(
        .LANES (LANES),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .store_vec  (store_vec),
        .wa3_in     (wa3_in),
        .stall      (stall),
        .done       (done),
        .load_vec   (load_vec),
        .wa3_out    (wa3_out),
        .vreg_we    (vreg_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
    } txn_t;

    txn_t          expQ[$];
    logic [DW-1:0] expLoad [LANES];
    logic [3:0]    expWa3;
    int            checks   = 0;
    int            failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compare the held results against the bench's prediction.
    task automatic checkState(input string tag);
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("%s_load_vec[%0d]", tag, i), 64'(load_vec[i]), 64'(expLoad[i]));
        end
        checkOutput({tag, "_wa3_out"}, 64'(wa3_out), 64'(expWa3));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_stall"},     64'(stall),     64'(0));
        checkOutput({tag, "_done"},      64'(done),      64'(0));
        checkOutput({tag, "_vreg_we"},   64'(vreg_we),   64'(0));
        checkOutput({tag, "_mem_req"},   64'(mem_req),   64'(0));
        checkOutput({tag, "_mem_we"},    64'(mem_we),    64'(0));
        checkOutput({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
        checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        checkOutput({tag, "_wa3_out"},   64'(wa3_out),   64'(0));
        for (int i = 0; i < LANES; i++) begin
            checkOutput($sformatf("%s_load_vec[%0d]", tag, i), 64'(load_vec[i]), 64'(0));
        end
    endtask

    // Idle cycles with spurious rvalid and random gnt; nothing may move.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            start      = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_0000 | 32'(k);
            mem_gnt    = 1'($urandom_range(0, 1));
            @(negedge CLK);
            checkOutput("idle_stall",   64'(stall),   64'(0));
            checkOutput("idle_mem_req", 64'(mem_req), 64'(0));
            checkOutput("idle_done",    64'(done),    64'(0));
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        checkState("idle");
    endtask

    // Launch one vector op and follow it to its done pulse. holdLane/holdCycles
    // withhold gnt on one lane; noisy toggles start and injects rvalid while a
    // request is pending; abortLane >= 0 fires RST when that lane is requested.
    task automatic applyStimulus(input bit st, input logic [AW-1:0] base, input logic [3:0] wa3,
                                 input logic [DW-1:0] salt, input int holdLane, input int holdCycles,
                                 input bit noisy, input int expDone, input int abortLane);
        int  popped      = 0;
        int  holdLeft    = holdCycles;
        bit  readPending = 1'b0;
        bit  wasRead;
        bit  finished    = 1'b0;
        txn_t t;

        for (int i = 0; i < LANES; i++) begin
            t.addr = AW'(base + AW'(4 * i));
            t.data = salt + DW'(i);
            t.we   = st;
            expQ.push_back(t);
            if (!st) expLoad[i] = salt + DW'(i);
        end
        expWa3 = wa3;

        // Cycle 0: request presented in IDLE.
        @(posedge CLK);
        #1;
        start      = 1'b1;
        is_store   = st;
        base_addr  = base;
        wa3_in     = wa3;
        for (int i = 0; i < LANES; i++) store_vec[i] = salt + DW'(i);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge CLK);
        checkOutput("c0_stall",   64'(stall),   64'(1));
        checkOutput("c0_mem_req", 64'(mem_req), 64'(0));
        checkOutput("c0_done",    64'(done),    64'(0));

        for (int cyc = 1; cyc <= expDone + 4 && !finished; cyc++) begin
            @(posedge CLK);
            #1;
            // Operands change under the DUT; only the values sampled at start count.
            base_addr = $urandom;
            wa3_in    = 4'($urandom);
            is_store  = ~st;
            for (int i = 0; i < LANES; i++) store_vec[i] = $urandom;
            start     = noisy ? 1'($urandom_range(0, 1)) : 1'b1;

            if (abortLane >= 0 && popped == abortLane && mem_req) begin
                start      = 1'b0;
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                RST        = 1'b1;
                expQ.delete();
                for (int i = 0; i < LANES; i++) expLoad[i] = '0;
                expWa3 = '0;
                @(negedge CLK);
                checkResetOutputs("abort");
                @(posedge CLK);
                checkOutput("abort_no_done", 64'(done), 64'(0));
                #1;
                RST = 1'b0;
                return;
            end

            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            wasRead    = 1'b0;
            if (readPending) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = salt + DW'(popped - 1);
                readPending = 1'b0;
                wasRead     = 1'b1;
            end else if (mem_req) begin
                if (popped == holdLane && holdLeft > 0) begin
                    holdLeft--;
                end else begin
                    mem_gnt = 1'b1;
                end
                if (noisy) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hDEAD_0000 | 32'(cyc);
                end
            end

            @(negedge CLK);
            if (done) begin
                checkOutput("done_cycle",    64'(cyc),         64'(expDone));
                checkOutput("done_vreg_we",  64'(vreg_we),     64'(!st));
                checkOutput("done_stall",    64'(stall),       64'(0));
                checkOutput("done_mem_req",  64'(mem_req),     64'(0));
                checkOutput("done_q_empty",  64'(expQ.size()), 64'(0));
                finished = 1'b1;
            end else begin
                checkOutput("busy_stall", 64'(stall), 64'(1));
                if (wasRead) begin
                    checkOutput("wait_mem_req", 64'(mem_req), 64'(0));
                end else if (mem_req) begin
                    if (expQ.size() == 0) begin
                        checkOutput("extra_req", 64'(mem_req), 64'(0));
                    end else begin
                        checkOutput($sformatf("addr_lane%0d", popped), 64'(mem_addr), 64'(expQ[0].addr));
                        checkOutput($sformatf("we_lane%0d", popped),   64'(mem_we),   64'(expQ[0].we));
                        if (st) begin
                            checkOutput($sformatf("wdata_lane%0d", popped), 64'(mem_wdata), 64'(expQ[0].data));
                        end
                        if (mem_gnt) begin
                            void'(expQ.pop_front());
                            popped++;
                            if (!st) readPending = 1'b1;
                        end
                    end
                end
                if (cyc == expDone) begin
                    checkOutput("done_at_expected_cycle", 64'(done), 64'(1));
                end
            end
        end
        if (!finished) begin
            checkOutput("done_timeout", 64'(0), 64'(1));
            expQ.delete();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        base_addr  = '0;
        store_vec  = '0;
        wa3_in     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < LANES; i++) expLoad[i] = '0;
        expWa3 = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkResetOutputs("reset");
        #1;
        RST = 1'b0;

        idleCycles(2);

        $display("[TB] store base 0x100, gnt tied high");
        applyStimulus(1'b1, 32'h0000_0100, 4'h3, 32'hA000_0000, -1, 0, 1'b0, 17, -1);
        checkState("store1");

        $display("[TB] load base 0x200, rvalid one cycle after gnt");
        applyStimulus(1'b0, 32'h0000_0200, 4'h7, 32'h0000_5500, -1, 0, 1'b0, 33, -1);
        checkState("load1");

        $display("[TB] back-to-back store with gnt held low 3 cycles at lane 5, noisy start/rvalid");
        applyStimulus(1'b1, 32'h0000_0400, 4'h2, 32'hC000_0000, 5, 3, 1'b1, 20, -1);
        checkState("store_hold");

        idleCycles(1);

        $display("[TB] load with spurious rvalid in REQ and start pulsed");
        applyStimulus(1'b0, 32'h0000_0800, 4'h9, 32'h0000_6600, -1, 0, 1'b1, 33, -1);
        checkState("load_noisy");

        $display("[TB] load aborted by RST at lane 8");
        applyStimulus(1'b0, 32'h0000_0300, 4'h5, 32'h0000_7700, -1, 0, 1'b0, 33, 8);
        checkState("abort");

        idleCycles(1);

        $display("[TB] load after abort");
        applyStimulus(1'b0, 32'h0000_0300, 4'h5, 32'h0000_7700, -1, 0, 1'b0, 33, -1);
        checkState("load_after_abort");

        $display("[TB] store with address wrap");
        applyStimulus(1'b1, 32'hFFFF_FFF8, 4'hE, 32'hB000_0000, -1, 0, 1'b0, 17, -1);
        checkState("wrap");

        idleCycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
